// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter: shares an HD44780-style character LCD between two
// character-write requesters once the initializer is done. Each grant issues
// a Set-DDRAM-Address command followed by a data write. All bus timing is
// produced by one counter, and RW is tied low, so the busy flag is never read.
//
// Handshake: req[i] is a level request. The requester holds req[i] and its
// addr/char steady until the grant edge. The block captures addr/char at the
// grant and pulses ack[i] for exactly one cycle when that write completes. If
// init_done falls mid-transfer the write is dropped without an ack; the
// requester re-serves it simply by keeping req[i] high.
module lcd_write_arbiter #(
  parameter int E_HIGH_CYCLES   = 12,
  parameter int CMD_WAIT_CYCLES = 2500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_done,
  input  logic [1:0] req,
  input  logic [6:0] addr0,
  input  logic [7:0] char0,
  input  logic [6:0] addr1,
  input  logic [7:0] char1,
  output logic [1:0] ack,
  output logic       busy,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       lcd_oe
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] ADDR_SETUP = 3'd1;
  localparam logic [2:0] ADDR_PULSE = 3'd2;
  localparam logic [2:0] ADDR_WAIT  = 3'd3;
  localparam logic [2:0] DATA_SETUP = 3'd4;
  localparam logic [2:0] DATA_PULSE = 3'd5;
  localparam logic [2:0] DATA_WAIT  = 3'd6;
  localparam logic [2:0] ACK        = 3'd7;

  // The counter only has to reach N-1 of the longer timed state.
  localparam int MAX_CYCLES = (E_HIGH_CYCLES > CMD_WAIT_CYCLES) ? E_HIGH_CYCLES : CMD_WAIT_CYCLES;
  localparam int CW         = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES);
  localparam logic [CW-1:0] E_LAST    = CW'(E_HIGH_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(CMD_WAIT_CYCLES - 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_grant_q, last_grant_d;
  logic [6:0]    addr_q, addr_d;
  logic [7:0]    char_q, char_d;
  logic          winner;

  // Next-state, arbitration and capture logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    char_d       = char_q;
    winner       = 1'b0;

    case (state_q)
      IDLE: begin
        if (init_done && (req != 2'b00)) begin
          // A lone request wins outright; a tie goes to the requester that
          // was not served last.
          if (req == 2'b01)      winner = 1'b0;
          else if (req == 2'b10) winner = 1'b1;
          else                   winner = ~last_grant_q;
          last_grant_d = winner;
          addr_d       = winner ? addr1 : addr0;
          char_d       = winner ? char1 : char0;
          state_d      = ADDR_SETUP;
        end
      end
      ADDR_SETUP: state_d = ADDR_PULSE;
      ADDR_PULSE: if (cnt_q == E_LAST)    state_d = ADDR_WAIT;
      ADDR_WAIT:  if (cnt_q == WAIT_LAST) state_d = DATA_SETUP;
      DATA_SETUP: state_d = DATA_PULSE;
      DATA_PULSE: if (cnt_q == E_LAST)    state_d = DATA_WAIT;
      DATA_WAIT:  if (cnt_q == WAIT_LAST) state_d = ACK;
      ACK:        state_d = IDLE;
      default:    state_d = IDLE;
    endcase

    // An initializer re-run takes the bus back immediately; last_grant keeps
    // its updated value so fairness is not disturbed.
    if (!init_done && (state_q != IDLE)) begin
      state_d = IDLE;
    end

    // One shared counter, restarted on every state change.
    if ((state_d != state_q) || (state_q == IDLE)) cnt_d = '0;
    else                                           cnt_d = cnt_q + 1'b1;
  end

  // State, counter and captured-request registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      char_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      char_q       <= char_d;
    end
  end

  // Bus outputs decoded from the registered state, so an asynchronous reset
  // clears them at once.
  always_comb begin
    ack      = 2'b00;
    lcd_rs   = 1'b0;
    lcd_e    = 1'b0;
    lcd_data = 8'h00;
    lcd_oe   = 1'b0;
    case (state_q)
      ADDR_SETUP, ADDR_PULSE, ADDR_WAIT: begin
        lcd_data = {1'b1, addr_q};
        lcd_oe   = 1'b1;
        lcd_e    = (state_q == ADDR_PULSE);
      end
      DATA_SETUP, DATA_PULSE, DATA_WAIT: begin
        lcd_rs   = 1'b1;
        lcd_data = char_q;
        lcd_oe   = 1'b1;
        lcd_e    = (state_q == DATA_PULSE);
      end
      ACK: ack = last_grant_q ? 2'b10 : 2'b01;
      default: ;
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// tb_lcd_write_arbiter: directed bench for lcd_write_arbiter with
// E_HIGH_CYCLES=2 and CMD_WAIT_CYCLES=4 (15-cycle grant-to-ack latency).
// A bus monitor records each command/data byte and pops the expected write
// from a queue whenever ack pulses.
module tb_lcd_write_arbiter;

  localparam int E_HIGH   = 2;
  localparam int CMD_WAIT = 4;
  localparam int LATENCY  = 2 * (1 + E_HIGH + CMD_WAIT) + 1;
  localparam int CLK_NS   = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       init_done;
  logic [1:0] req;
  logic [6:0] addr0, addr1;
  logic [7:0] char0, char1;
  logic [1:0] ack;
  logic       busy, lcd_rs, lcd_rw, lcd_e, lcd_oe;
  logic [7:0] lcd_data;

  int n_assert = 0;
  int n_fail   = 0;

  // Expected write: {port, command byte, character byte}.
  logic [16:0] exp_q[$];
  logic        model_last;

  lcd_write_arbiter #(
    .E_HIGH_CYCLES  (E_HIGH),
    .CMD_WAIT_CYCLES(CMD_WAIT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .init_done(init_done),
    .req      (req),
    .addr0    (addr0),
    .char0    (char0),
    .addr1    (addr1),
    .char1    (char1),
    .ack      (ack),
    .busy     (busy),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_e    (lcd_e),
    .lcd_data (lcd_data),
    .lcd_oe   (lcd_oe)
  );

  // Clock and watchdog.
  always #(CLK_NS / 2) clk = ~clk;

  initial begin
    #(200000 * CLK_NS);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected result of a grant, with the round-robin model updated.
  task automatic push_grant(input logic [1:0] r, input logic [6:0] a0, input logic [7:0] c0,
                            input logic [6:0] a1, input logic [7:0] c1);
    logic w;
    if (r == 2'b01)      w = 1'b0;
    else if (r == 2'b10) w = 1'b1;
    else                 w = ~model_last;
    model_last = w;
    exp_q.push_back(w ? {1'b1, 1'b1, a1, c1} : {1'b0, 1'b1, a0, c0});
  endtask

  task automatic wait_ack(output time t);
    int n;
    n = 0;
    t = 0;
    while (n < 100) begin
      @(negedge clk);
      if (ack != 2'b00) begin
        t = $time;
        break;
      end
      n++;
    end
    if (n >= 100) chk("ack_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_busy();
    int n;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (busy) break;
      n++;
    end
    if (n >= 100) chk("busy_timeout", 32'd1, 32'd0);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Bus monitor / scoreboard, sampled on the falling edge.
  int          cyc = 0;
  int          busy_start = 0;
  int          e_width = 0;
  logic        e_rs = 1'b0;
  logic        e_prev = 1'b0;
  logic        busy_prev = 1'b0;
  logic [7:0]  got_cmd = 8'h00;
  logic [7:0]  got_char = 8'h00;
  logic [16:0] ent;

  always @(negedge clk) begin
    cyc++;
    if (busy && !busy_prev) busy_start = cyc;
    if (lcd_e && !e_prev) begin
      e_width = 0;
      e_rs    = lcd_rs;
    end
    if (lcd_e) begin
      e_width++;
      chk("oe_with_e", {31'd0, lcd_oe}, 32'd1);
      chk("rs_stable_in_pulse", {31'd0, lcd_rs}, {31'd0, e_rs});
      if (e_rs) got_char = lcd_data;
      else      got_cmd  = lcd_data;
    end
    if (!lcd_e && e_prev && busy) chk("e_width", e_width, E_HIGH);
    if (ack != 2'b00) begin
      if (exp_q.size() == 0) begin
        chk("ack_unexpected", {30'd0, ack}, 32'd0);
      end else begin
        ent = exp_q.pop_front();
        chk("ack_port", {30'd0, ack}, ent[16] ? 32'd2 : 32'd1);
        chk("cmd_byte", {24'd0, got_cmd}, {24'd0, ent[15:8]});
        chk("char_byte", {24'd0, got_char}, {24'd0, ent[7:0]});
        chk("ack_latency", cyc - busy_start + 1, LATENCY);
      end
    end
    e_prev    = lcd_e;
    busy_prev = busy;
  end

  time t1, t2, t3;

  initial begin
    // Reset held with requests pending and initialisation incomplete.
    reset = 1'b1; init_done = 1'b0; req = 2'b11;
    addr0 = 7'h00; char0 = 8'h00; addr1 = 7'h00; char1 = 8'h00;
    model_last = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("reset_outputs", {17'd0, ack, busy, lcd_rs, lcd_rw, lcd_e, lcd_oe, lcd_data}, 32'd0);
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_grant_before_init", {29'd0, busy, ack}, 32'd0);
    end

    // Single write from requester 0.
    req = 2'b00;
    @(negedge clk);
    init_done = 1'b1; req = 2'b01; addr0 = 7'h40; char0 = 8'h41;
    push_grant(req, addr0, char0, addr1, char1);
    wait_ack(t1);
    req = 2'b00;
    cycles(2);

    // Both requesting across three transactions: strict alternation.
    req = 2'b11; addr0 = 7'h01; char0 = 8'h30; addr1 = 7'h45; char1 = 8'h31;
    push_grant(req, addr0, char0, addr1, char1);
    push_grant(req, addr0, char0, addr1, char1);
    push_grant(req, addr0, char0, addr1, char1);
    wait_ack(t1);
    wait_ack(t2);
    wait_ack(t3);
    req = 2'b00;
    chk("b2b_spacing_1", 32'((t2 - t1) / CLK_NS), LATENCY + 1);
    chk("b2b_spacing_2", 32'((t3 - t2) / CLK_NS), LATENCY + 1);
    cycles(2);

    // Inputs changed and req dropped during ADDR_WAIT: captured values win.
    req = 2'b01; addr0 = 7'h12; char0 = 8'h55;
    push_grant(req, addr0, char0, addr1, char1);
    wait_busy();
    cycles(4);
    chk("in_addr_wait", {29'd0, lcd_e, lcd_rs, lcd_oe}, 32'b001);
    addr0 = 7'h33; char0 = 8'h66; req = 2'b00;
    wait_ack(t1);
    cycles(2);

    // init_done falls during DATA_PULSE: abort, then restart from scratch.
    req = 2'b10; addr1 = 7'h27; char1 = 8'h77;
    push_grant(req, addr0, char0, addr1, char1);
    wait_busy();
    cycles(8);
    chk("in_data_pulse", {30'd0, lcd_e, lcd_rs}, 32'b11);
    init_done = 1'b0;
    @(negedge clk);
    chk("abort_idle", {27'd0, busy, lcd_e, lcd_oe, ack}, 32'd0);
    chk("abort_rs", {31'd0, lcd_rs}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_hold", {29'd0, busy, ack}, 32'd0);
    end
    init_done = 1'b1;
    wait_busy();
    chk("restart_addr_setup", {21'd0, lcd_data, lcd_rs, lcd_e, lcd_oe}, {21'd0, 8'hA7, 3'b001});
    wait_ack(t1);
    req = 2'b00;
    cycles(2);

    // Asynchronous reset during ADDR_PULSE, then requester 1 served.
    req = 2'b01; addr0 = 7'h05; char0 = 8'h10;
    wait_busy();
    @(negedge clk);
    chk("in_addr_pulse", {31'd0, lcd_e}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", {17'd0, ack, busy, lcd_rs, lcd_rw, lcd_e, lcd_oe, lcd_data}, 32'd0);
    exp_q.delete();
    model_last = 1'b1;
    req = 2'b10; addr1 = 7'h60; char1 = 8'h61;
    push_grant(req, addr0, char0, addr1, char1);
    @(negedge clk);
    reset = 1'b0;
    wait_ack(t1);
    req = 2'b00;
    cycles(3);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
